// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits per clock, LSB digit first,
// with a valid/ready handshake on both sides and registered result flags.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNTW-1:0] LAST_DIG = CNTW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [CNTW-1:0]  cnt_q;
   logic             cy_q, carry_q, ovf_q;

   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_co;
   logic [WIDTH-1:0] sum_d;
   logic             ovf_d;

   // Operands shift right each RUN cycle so the active digit always sits at bit 0;
   // result digits enter at the top, leaving the full sum aligned after NDIG cycles.
   always_comb begin
      dig_a           = a_q[DIGIT-1:0];
      dig_b           = b_q[DIGIT-1:0];
      {dig_co, dig_s} = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, cy_q};
      sum_d           = WIDTH'({dig_s, sum_q} >> DIGIT);
      // Carry into the MSB is recovered as a ^ b ^ s of that bit.
      ovf_d           = dig_co ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dig_s[DIGIT-1];
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order inside the block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  cy_q    <= sub;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               sum_q <= sum_d;
               cy_q  <= dig_co;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_DIG) begin
                  carry_q <= dig_co;
                  ovf_q   <= ovf_d;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: port 0 is WIDTH=8/DIGIT=1, port 1 is WIDTH=8/DIGIT=4.
// Stimulus pushes arithmetic-model results; a monitor pops them on each output handshake.
module tb_serial_adder;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
   } res_t;

   typedef struct packed {
      res_t r;
      int   acc_cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid [2];
   logic         in_ready [2];
   logic         sub      [2];
   logic         out_valid[2];
   logic         out_ready[2];
   logic         carry    [2];
   logic         overflow [2];
   logic [W-1:0] a        [2];
   logic [W-1:0] b        [2];
   logic [W-1:0] sum      [2];
   int           ready_mode[2];   // 0: always ready, 1: random, 2: held low
   int           cyc   = 0;
   int           n_vec = 0;
   int           n_err = 0;
   exp_t         sb0[$];
   exp_t         sb1[$];

   serial_adder #(.WIDTH(W), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a[0]), .b(b[0]), .sub(sub[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .sum(sum[0]), .carry(carry[0]), .overflow(overflow[0])
   );

   serial_adder #(.WIDTH(W), .DIGIT(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a[1]), .b(b[1]), .sub(sub[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .sum(sum[1]), .carry(carry[1]), .overflow(overflow[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ndig(input int p);
      return (p == 0) ? 8 : 2;
   endfunction

   // Reference: plain unsigned and signed arithmetic on the operand values.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      res_t r;
      int   ux, uy, sx, sy, sr;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (s) begin
         r.sum   = W'(ux - uy);
         r.carry = (ux >= uy);
         sr      = sx - sy;
      end else begin
         r.sum   = W'(ux + uy);
         r.carry = (ux + uy) > 255;
         sr      = sx + sy;
      end
      r.ovf = (sr > 127) || (sr < -128);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   function automatic int sb_size(input int p);
      if (p == 0) return sb0.size();
      return sb1.size();
   endfunction

   function automatic exp_t sb_front(input int p);
      if (p == 0) return sb0[0];
      return sb1[0];
   endfunction

   task automatic sb_push(input int p, input exp_t e);
      if (p == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic sb_pop(input int p, output exp_t e);
      if (p == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
   endtask

   // Present operands until accepted, then scramble the inputs to show they are ignored.
   task automatic issue(input int p, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t e;
      int   waited = 0;
      @(negedge clk);
      a[p] = x; b[p] = y; sub[p] = s; in_valid[p] = 1'b1;
      while (in_ready[p] !== 1'b1) begin
         if (waited++ > 100) begin
            timeout($sformatf("p%0d accept", p));
            in_valid[p] = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      e.r       = model(x, y, s);
      e.acc_cyc = cyc;
      sb_push(p, e);
      in_valid[p] = 1'b0;
      a[p] = W'($urandom); b[p] = W'($urandom); sub[p] = 1'($urandom);
   endtask

   task automatic wait_drain(input int p);
      int n = 0;
      while (!(sb_size(p) == 0 && in_ready[p] === 1'b1)) begin
         if (n++ > 300) begin
            timeout($sformatf("p%0d drain", p));
            return;
         end
         @(negedge clk);
         #2;
      end
   endtask

   task automatic wait_valid(input int p);
      int n = 0;
      while (out_valid[p] !== 1'b1) begin
         if (n++ > 50) begin
            timeout($sformatf("p%0d out_valid", p));
            return;
         end
         @(negedge clk);
         #1;
      end
   endtask

   // Consumer: drives out_ready on every falling edge according to ready_mode.
   initial begin
      forever begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            case (ready_mode[p])
               0:       out_ready[p] = 1'b1;
               1:       out_ready[p] = 1'($urandom_range(0, 1));
               default: out_ready[p] = 1'b0;
            endcase
         end
      end
   end

   // Monitor: checks latency on out_valid rise and the result on each handshake.
   initial begin : monitor
      logic prev_v[2];
      exp_t e;
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (rst) begin
               prev_v[p] = 1'b0;
            end else begin
               if (out_valid[p] === 1'b1 && !prev_v[p]) begin
                  if (sb_size(p) == 0) begin
                     n_vec++;
                     n_err++;
                     $display("FAIL p%0d unexpected result: sum 0x%0h with nothing pending", p, sum[p]);
                  end else begin
                     e = sb_front(p);
                     check($sformatf("p%0d latency", p), 32'(cyc - e.acc_cyc), 32'(ndig(p)));
                  end
               end
               if (out_valid[p] === 1'b1 && out_ready[p] === 1'b1 && sb_size(p) > 0) begin
                  sb_pop(p, e);
                  check($sformatf("p%0d sum", p),      32'(sum[p]),      32'(e.r.sum));
                  check($sformatf("p%0d carry", p),    32'(carry[p]),    32'(e.r.carry));
                  check($sformatf("p%0d overflow", p), 32'(overflow[p]), 32'(e.r.ovf));
               end
               prev_v[p] = (out_valid[p] === 1'b1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      res_t held;
      exp_t dropped;
      for (int p = 0; p < 2; p++) begin
         in_valid[p] = 1'b0; a[p] = '0; b[p] = '0; sub[p] = 1'b0; ready_mode[p] = 0;
      end

      #2 rst = 1'b1;
      #1;
      for (int p = 0; p < 2; p++) begin
         check($sformatf("p%0d reset in_ready", p),  32'(in_ready[p]),  32'd1);
         check($sformatf("p%0d reset out_valid", p), 32'(out_valid[p]), 32'd0);
         check($sformatf("p%0d reset sum", p),       32'(sum[p]),       32'd0);
         check($sformatf("p%0d reset carry", p),     32'(carry[p]),     32'd0);
         check($sformatf("p%0d reset overflow", p),  32'(overflow[p]),  32'd0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Directed add/subtract corners on the bit-serial instance.
      issue(0, 8'h00, 8'h00, 1'b0); wait_drain(0);
      issue(0, 8'hFF, 8'h01, 1'b0); wait_drain(0);
      issue(0, 8'h7F, 8'h01, 1'b0); wait_drain(0);
      issue(0, 8'h05, 8'h07, 1'b1); wait_drain(0);
      issue(0, 8'h80, 8'h01, 1'b1); wait_drain(0);

      // Back-pressure: result must hold while the consumer stalls.
      ready_mode[0] = 2;
      issue(0, 8'h3C, 8'h15, 1'b0);
      held = model(8'h3C, 8'h15, 1'b0);
      wait_valid(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid[0] = i[0];
         a[0] = W'($urandom); b[0] = W'($urandom); sub[0] = 1'($urandom);
         #1;
         check("bp out_valid", 32'(out_valid[0]), 32'd1);
         check("bp sum",       32'(sum[0]),       32'(held.sum));
         check("bp in_ready",  32'(in_ready[0]),  32'd0);
      end
      in_valid[0] = 1'b0;
      ready_mode[0] = 0;
      wait_drain(0);
      repeat (3) @(negedge clk);
      #1;
      check("bp no extra accept", 32'(in_ready[0]), 32'd1);

      // Reset while processing digit 3 aborts the operation.
      issue(0, 8'hA5, 8'h3C, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort out_valid", 32'(out_valid[0]), 32'd0);
      check("abort in_ready",  32'(in_ready[0]),  32'd1);
      check("abort sum",       32'(sum[0]),       32'd0);
      check("abort carry",     32'(carry[0]),     32'd0);
      check("abort overflow",  32'(overflow[0]),  32'd0);
      sb_pop(0, dropped);
      @(negedge clk) rst = 1'b0;
      issue(0, 8'h12, 8'h34, 1'b0); wait_drain(0);

      // Nibble-serial instance: two-cycle latency and bit-0 half-adder corners.
      issue(1, 8'h99, 8'h77, 1'b0); wait_drain(1);
      for (int i = 0; i < 4; i++) begin
         issue(1, {7'($urandom), i[1]}, {7'($urandom), i[0]}, 1'b0);
      end
      wait_drain(1);

      // Randomized traffic on both instances with a random consumer.
      ready_mode[0] = 1;
      ready_mode[1] = 1;
      fork
         for (int i = 0; i < 40; i++) issue(0, W'($urandom), W'($urandom), 1'($urandom));
         for (int i = 0; i < 40; i++) issue(1, W'($urandom), W'($urandom), 1'($urandom));
      join
      wait_drain(0);
      wait_drain(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits (legal: >=2).
REQ-002 The block SHALL have parameter DIGIT, default 1: bits processed per clock (legal: 1..WIDTH, must divide WIDTH); NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and mode present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-013 The block SHALL have port carry, output, 1 bit: carry out of MSB (for sub: 1 = no borrow).
REQ-014 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 The block SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE, both decoded from state (registered, no input paths).
REQ-017 Accept SHALL occur on an edge with state IDLE and in_valid = 1: latch a; latch b (inverted if sub = 1); set carry register = sub; clear digit counter; enter RUN.
REQ-018 IDLE with in_valid = 0 SHALL remain IDLE; a, b and sub SHALL be ignored outside an accept edge.
REQ-019 Each RUN edge SHALL add digit i of A, digit i of B' and the carry register, write DIGIT result bits to sum[i*DIGIT +: DIGIT], update the carry register, and increment i, LSB digit first.
REQ-020 On the edge processing digit NDIG-1 the block SHALL capture carry = final carry out and overflow = carry into MSB XOR carry out of MSB, then enter DONE.
REQ-021 Latency: with accept at edge k, out_valid SHALL be 1 from edge k+NDIG (exactly NDIG RUN cycles).
REQ-022 DONE SHALL hold sum, carry and overflow stable until an edge with out_ready = 1, then enter IDLE; the next accept is possible at the following edge at the earliest.
REQ-023 out_ready asserted outside DONE SHALL have no effect.
REQ-024 sum, carry and overflow SHALL hold the last result after leaving DONE, until the next accept; partial sum bits are not meaningful while in RUN.
REQ-025 The digit counter SHALL be ceil(log2(NDIG)) bits, minimum 1; for NDIG = 1, RUN SHALL last exactly one cycle.

Reset
REQ-026 rst = 1 SHALL immediately, without a clock, force state IDLE, in_ready = 1, out_valid = 0, sum = 0, carry = 0, overflow = 0, and clear the digit counter and the carry register.
REQ-027 rst asserted in RUN or DONE SHALL abort the operation with no result delivered; after rst deasserts, the first edge with in_valid = 1 SHALL accept normally.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-028 The bench SHALL check: accept a=0x00, b=0x00, sub=0 -> out_valid rises exactly 8 edges after accept, sum=0x00, carry=0, overflow=0.
REQ-029 The bench SHALL check: a=0xFF, b=0x01, sub=0 -> sum=0x00, carry=1, overflow=0; then a=0x7F, b=0x01 -> sum=0x80, carry=0, overflow=1.
REQ-030 The bench SHALL check: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0, overflow=0; then a=0x80, b=0x01, sub=1 -> sum=0x7F, carry=1, overflow=1.
REQ-031 The bench SHALL check back-pressure: out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, sum stable, in_ready stays 0, and in_valid pulses are ignored.
REQ-032 The bench SHALL check reset: rst pulsed at RUN digit 3 -> out_valid=0, in_ready=1 and sum=0 with no clock; the next operation (0x12+0x34) returns sum=0x46.
REQ-033 The bench SHALL check WIDTH=8, DIGIT=4: a=0x99, b=0x77 -> latency 2 edges, sum=0x10, carry=1; it SHALL also check all 4 half-adder corner pairs in bit 0 (0+0, 0+1, 1+0, 1+1) -> sum bit0 = 0, 1, 1, 0.
